csr_trap_unit: RTL and testbench
================================

Name: csr_trap_unit

Overview:
Parametrised successor to the machine-mode CSR block: M-mode CSR file plus trap/return sequencer for the single-cycle RV32 core. Adds N platform-local interrupts (mip/mie bits 16+), correct CSRRS/CSRRC write suppression, illegal-CSR detection, mtval capture, and 64-bit cycle/instret counters with carry and inhibit. Sits beside the decoder/writeback stage and drives PC redirect on trap or mret.

Parameters:
XLEN, 32, datapath width; only 32 supported.
NUM_LOCAL_IRQ, 4, platform-local interrupt lines, range 0..16, mapped to mip/mie bits 16..16+N-1.
MHARTID_VAL, 0, constant value read from mhartid.
MISA_VAL, 32'h4000_0100, constant value read from misa (RV32I); writes ignored.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
irq_ext_in / irq_sw_in / irq_timer_in  in  1 each  level interrupt requests
irq_local_in  in  NUM_LOCAL_IRQ  level local interrupt requests
illegal_instr_in / ecall_in / ebreak_in  in  1 each  decoder exceptions
load_misaligned_in / store_misaligned_in  in  1 each  LSU exceptions
bad_addr_in  in  XLEN  faulting address for misaligned load/store
instr_in  in  32  current instruction word, for illegal-instruction mtval
mret_in  in  1  mret decoded
csr_valid_in  in  1  Zicsr instruction this cycle
csr_op_in  in  3  funct3: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
csr_addr_in  in  12  CSR index
rs1_in  in  XLEN  rs1 value
rs1_idx_in  in  5  rs1 field, doubles as zimm
pc_in  in  XLEN  current PC
instret_in  in  1  current instruction retires
csr_rdata_out  out  XLEN  old CSR value to rd
trap_taken_out  out  1  redirect to trap_pc_out
trap_pc_out  out  XLEN  trap vector
mret_taken_out  out  1  redirect to mepc_out
mepc_out  out  XLEN  current mepc

Behaviour:
- Reset (reset low, async): mstatus, mie, mip, mtvec, mscratch, mepc, mcause, mtval, mcycle[h], minstret[h], mcountinhibit = 0. All outputs are combinational from state and inputs; with reset held and no inputs asserted, every output is 0.
- Registered interrupt sampling: each edge mip[3]<=irq_sw, mip[7]<=irq_timer, mip[11]<=irq_ext, mip[16+i]<=irq_local[i]; software writes to mip are ignored. A request reaches pending one cycle after assertion.
- Pending = mip & mie & {XLEN{mstatus.MIE}}. Priority: MEI(11) > MSI(3) > MTI(7) > local 16 > 17 > ... (lowest index first).
- Exception priority: illegal > ecall(11) / ebreak(3) > load misaligned(4) > store misaligned(6). Pending interrupt outranks any exception.
- trap_taken_out = any pending interrupt OR any exception. On that edge: mepc<=pc_in; mcause<={is_int, cause}; mtval <= instr_in (illegal), bad_addr_in (misaligned), else 0; MPIE<=MIE; MIE<=0; MPP<=2'b11.
- trap_pc_out = {mtvec[31:2],2'b00}, plus 4*cause in vectored mode for interrupts only.
- mret_taken_out = mret_in & ~trap_taken_out. On that edge MIE<=MPIE, MPIE<=1, MPP<=11. A trap in the same cycle wins.
- CSR access: csr_rdata_out = old value. New value is wdata (RW), old|src (RS), old&~src (RC); src = rs1_in, or zero-extended rs1_idx_in for the I forms.
- No write for RS/RC/RSI/RCI when rs1_idx_in==0; reads and side effects still occur.
- Unimplemented address, or any write to a read-only CSR (0xF11-0xF14, misa write is ignored, not illegal), raises internal csr_illegal, which is ORed into illegal_instr: trap with mcause 2, mtval=instr_in, no CSR update.
- Any trap suppresses that cycle's CSR write and instret increment.
- WARL: mepc[1:0] reads 0. mstatus writable bits are 3 and 7 only; MPP reads 11. mie writable bits are 3, 7, 11 and 16..16+N-1. mcountinhibit writable bits are 0 and 2.
- Counters: mcycle/mcycleh form 64 bits and increment every cycle unless mcountinhibit[0]. Low-word wrap 0xFFFFFFFF carries into the high word. minstret[h] increments on instret_in & ~trap unless mcountinhibit[2]. A CSR write to either half takes precedence over the increment that cycle; the other half holds.

Optional Feature:
CSR_VECTORED_EN: defined -> mtvec[1:0] writable as 0/1 (values 2/3 are stored as 0), and mode 1 vectors interrupts to base+4*cause. Undefined -> mtvec[1:0] hardwired 0, direct mode only.

Test Plan:
- Reset low mid-run with mcycle=0x1234 -> all CSRs read 0 immediately. After release, mcycle reads 1 after one edge.
- csrrw mtvec,0x100 (value 0x101 with CSR_VECTORED_EN); set MIE and mie[7]; assert irq_timer -> trap on second cycle. Expect trap_pc=0x11C, mcause=0x80000007, mepc=pc, MIE=0, MPIE=1.
- csrrs x5,mscratch,x0 with mscratch=0xAA -> rd=0xAA, no write. csrrci mstatus,8 with MIE=1 -> MIE=0.
- Write mcycle=0xFFFFFFFF, mcycleh=0 -> next cycle reads mcycle 0, mcycleh 1. Set mcountinhibit=1 -> value holds.
- Simultaneous irq_ext and ecall with enabled -> mcause=0x8000000B. mret together with a pending interrupt -> trap taken, mret_taken=0.
- csrrw to 0xF11 with instr 0x34... -> trap, mcause=2, mtval=instr_in, minstret unchanged. Misaligned load at 0x1003 -> mcause=4, mtval=0x1003.

Source files
------------

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file plus trap / mret sequencer for the
// single-cycle RV32 core. Decodes Zicsr accesses, samples interrupt lines,
// prioritises interrupts and exceptions, and drives the PC redirect.
// Optional build macro: CSR_VECTORED_EN (vectored mtvec mode for interrupts).
module csr_trap_unit #(
    parameter int          XLEN          = 32,
    parameter int          NUM_LOCAL_IRQ = 4,
    parameter logic [31:0] MHARTID_VAL   = 32'h0,
    parameter logic [31:0] MISA_VAL      = 32'h4000_0100
) (
    input  logic                                              clk,
    input  logic                                              reset,
    input  logic                                              irq_ext_in,
    input  logic                                              irq_sw_in,
    input  logic                                              irq_timer_in,
    input  logic [((NUM_LOCAL_IRQ > 0) ? NUM_LOCAL_IRQ : 1)-1:0] irq_local_in,
    input  logic                                              illegal_instr_in,
    input  logic                                              ecall_in,
    input  logic                                              ebreak_in,
    input  logic                                              load_misaligned_in,
    input  logic                                              store_misaligned_in,
    input  logic [XLEN-1:0]                                   bad_addr_in,
    input  logic [31:0]                                       instr_in,
    input  logic                                              mret_in,
    input  logic                                              csr_valid_in,
    input  logic [2:0]                                        csr_op_in,
    input  logic [11:0]                                       csr_addr_in,
    input  logic [XLEN-1:0]                                   rs1_in,
    input  logic [4:0]                                        rs1_idx_in,
    input  logic [XLEN-1:0]                                   pc_in,
    input  logic                                              instret_in,
    output logic [XLEN-1:0]                                   csr_rdata_out,
    output logic                                              trap_taken_out,
    output logic [XLEN-1:0]                                   trap_pc_out,
    output logic                                              mret_taken_out,
    output logic [XLEN-1:0]                                   mepc_out
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MCOUNTINH = 12'h320;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MVENDORID = 12'hF11;
    localparam logic [11:0] ADDR_MARCHID   = 12'hF12;
    localparam logic [11:0] ADDR_MIMPID    = 12'hF13;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    // Writable mie bits: MSI, MTI, MEI and one bit per local interrupt line.
    localparam logic [63:0] LOCAL_ONES = (64'h1 << NUM_LOCAL_IRQ) - 64'h1;
    localparam logic [31:0] MIE_WMASK  = {LOCAL_ONES[15:0], 16'h0888};

    logic            mstatus_mie, mstatus_mpie;
    logic [1:0]      mstatus_mpp;
    logic [XLEN-1:0] mie_q, mip_q, mtvec_q, mscratch_q, mepc_q;
    logic [XLEN-1:0] mcause_q, mtval_q, mcountinhibit_q;
    logic [63:0]     mcycle_q, minstret_q;

    logic [XLEN-1:0] mip_sample, pending;
    logic [XLEN-1:0] csr_old, csr_src, csr_wdata, exc_tval, trap_tval;
    logic            csr_impl, csr_ro, csr_wr_intent, csr_illegal, csr_we;
    logic            int_valid, exc_valid, trap_taken, instret_inc;
    logic [4:0]      int_cause, exc_cause, trap_cause;
    logic [XLEN-1:0] tvec_base;

    // Gather the raw interrupt lines into their mip bit positions.
    always_comb begin
        mip_sample     = '0;
        mip_sample[3]  = irq_sw_in;
        mip_sample[7]  = irq_timer_in;
        mip_sample[11] = irq_ext_in;
        for (int i = 0; i < NUM_LOCAL_IRQ; i++) begin
            mip_sample[16+i] = irq_local_in[i];
        end
    end

    // CSR read mux; unknown addresses flag themselves as unimplemented.
    always_comb begin
        csr_impl = 1'b1;
        csr_old  = '0;
        case (csr_addr_in)
            ADDR_MSTATUS:   csr_old = {19'b0, mstatus_mpp, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
            ADDR_MISA:      csr_old = MISA_VAL;
            ADDR_MIE:       csr_old = mie_q;
            ADDR_MTVEC:     csr_old = mtvec_q;
            ADDR_MCOUNTINH: csr_old = mcountinhibit_q;
            ADDR_MSCRATCH:  csr_old = mscratch_q;
            ADDR_MEPC:      csr_old = mepc_q;
            ADDR_MCAUSE:    csr_old = mcause_q;
            ADDR_MTVAL:     csr_old = mtval_q;
            ADDR_MIP:       csr_old = mip_q;
            ADDR_MCYCLE:    csr_old = mcycle_q[31:0];
            ADDR_MCYCLEH:   csr_old = mcycle_q[63:32];
            ADDR_MINSTRET:  csr_old = minstret_q[31:0];
            ADDR_MINSTRETH: csr_old = minstret_q[63:32];
            ADDR_MVENDORID, ADDR_MARCHID, ADDR_MIMPID: csr_old = '0;
            ADDR_MHARTID:   csr_old = MHARTID_VAL;
            default:        csr_impl = 1'b0;
        endcase
    end

    // Set/clear forms with rs1 = x0 (or zimm = 0) are pure reads.
    assign csr_ro        = (csr_addr_in[11:10] == 2'b11);
    assign csr_wr_intent = (csr_op_in[1:0] == 2'b01) || (rs1_idx_in != 5'd0);
    assign csr_illegal   = csr_valid_in && (!csr_impl || (csr_ro && csr_wr_intent));
    assign csr_src       = csr_op_in[2] ? {27'b0, rs1_idx_in} : rs1_in;

    // Read-modify-write value for RW / RS / RC forms.
    always_comb begin
        case (csr_op_in[1:0])
            2'b01:   csr_wdata = csr_src;
            2'b10:   csr_wdata = csr_old | csr_src;
            2'b11:   csr_wdata = csr_old & ~csr_src;
            default: csr_wdata = csr_old;
        endcase
    end

    // Interrupt arbitration: MEI > MSI > MTI > local lines, lowest index first.
    always_comb begin
        pending   = mip_q & mie_q & {XLEN{mstatus_mie}};
        int_valid = 1'b1;
        int_cause = 5'd0;
        if (pending[11])     int_cause = 5'd11;
        else if (pending[3]) int_cause = 5'd3;
        else if (pending[7]) int_cause = 5'd7;
        else begin
            int_valid = 1'b0;
            for (int i = NUM_LOCAL_IRQ - 1; i >= 0; i--) begin
                if (pending[16+i]) begin
                    int_valid = 1'b1;
                    int_cause = 5'(16 + i);
                end
            end
        end
    end

    // Exception arbitration and the matching mtval payload.
    always_comb begin
        exc_valid = 1'b1;
        exc_cause = 5'd0;
        exc_tval  = '0;
        if (illegal_instr_in || csr_illegal) begin
            exc_cause = 5'd2;
            exc_tval  = instr_in;
        end else if (ecall_in) begin
            exc_cause = 5'd11;
        end else if (ebreak_in) begin
            exc_cause = 5'd3;
        end else if (load_misaligned_in) begin
            exc_cause = 5'd4;
            exc_tval  = bad_addr_in;
        end else if (store_misaligned_in) begin
            exc_cause = 5'd6;
            exc_tval  = bad_addr_in;
        end else begin
            exc_valid = 1'b0;
        end
    end

    assign trap_taken  = int_valid || exc_valid;
    assign trap_cause  = int_valid ? int_cause : exc_cause;
    assign trap_tval   = int_valid ? '0 : exc_tval;
    assign csr_we      = csr_valid_in && csr_wr_intent && !trap_taken;
    assign instret_inc = instret_in && !trap_taken && !mcountinhibit_q[2];
    assign tvec_base   = {mtvec_q[XLEN-1:2], 2'b00};

    assign csr_rdata_out  = csr_valid_in ? csr_old : '0;
    assign trap_taken_out = trap_taken;
    assign mret_taken_out = mret_in && !trap_taken;
    assign mepc_out       = mepc_q;
`ifdef CSR_VECTORED_EN
    assign trap_pc_out = (int_valid && mtvec_q[0]) ? tvec_base + {25'b0, trap_cause, 2'b00} : tvec_base;
`else
    assign trap_pc_out = tvec_base;
`endif

    // Interrupt lines are sampled every edge; software cannot write mip.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mip_q <= '0;
        else        mip_q <= mip_sample;
    end

    // mstatus: trap entry beats mret, which beats a software write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mstatus_mpp  <= 2'b00;
        end else if (trap_taken) begin
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
            mstatus_mpp  <= 2'b11;
        end else if (mret_in) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
            mstatus_mpp  <= 2'b11;
        end else if (csr_we && csr_addr_in == ADDR_MSTATUS) begin
            mstatus_mie  <= csr_wdata[3];
            mstatus_mpie <= csr_wdata[7];
        end
    end

    // Trap-capture CSRs: loaded on trap entry, otherwise software-writable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mepc_q   <= '0;
            mcause_q <= '0;
            mtval_q  <= '0;
        end else if (trap_taken) begin
            mepc_q   <= {pc_in[XLEN-1:2], 2'b00};
            mcause_q <= {int_valid, 26'b0, trap_cause};
            mtval_q  <= trap_tval;
        end else if (csr_we) begin
            if (csr_addr_in == ADDR_MEPC)   mepc_q   <= {csr_wdata[XLEN-1:2], 2'b00};
            if (csr_addr_in == ADDR_MCAUSE) mcause_q <= csr_wdata;
            if (csr_addr_in == ADDR_MTVAL)  mtval_q  <= csr_wdata;
        end
    end

    // Plain software-owned CSRs with their WARL masks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mie_q           <= '0;
            mtvec_q         <= '0;
            mscratch_q      <= '0;
            mcountinhibit_q <= '0;
        end else if (csr_we) begin
            if (csr_addr_in == ADDR_MIE)       mie_q           <= csr_wdata & MIE_WMASK;
            if (csr_addr_in == ADDR_MSCRATCH)  mscratch_q      <= csr_wdata;
            if (csr_addr_in == ADDR_MCOUNTINH) mcountinhibit_q <= csr_wdata & 32'h5;
`ifdef CSR_VECTORED_EN
            if (csr_addr_in == ADDR_MTVEC)     mtvec_q <= {csr_wdata[XLEN-1:2], 1'b0, (csr_wdata[1:0] == 2'b01)};
`else
            if (csr_addr_in == ADDR_MTVEC)     mtvec_q <= {csr_wdata[XLEN-1:2], 2'b00};
`endif
        end
    end

    // 64-bit counters: a write to either half freezes the pair for that edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            if (csr_we && csr_addr_in == ADDR_MCYCLE)       mcycle_q[31:0]  <= csr_wdata;
            else if (csr_we && csr_addr_in == ADDR_MCYCLEH) mcycle_q[63:32] <= csr_wdata;
            else if (!mcountinhibit_q[0])                   mcycle_q        <= mcycle_q + 64'd1;

            if (csr_we && csr_addr_in == ADDR_MINSTRET)       minstret_q[31:0]  <= csr_wdata;
            else if (csr_we && csr_addr_in == ADDR_MINSTRETH) minstret_q[63:32] <= csr_wdata;
            else if (instret_inc)                             minstret_q        <= minstret_q + 64'd1;
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed scenarios with literal expectations, followed by
// randomized traffic, all compared each cycle against a behavioural model.
module tb_csr_trap_unit;

    localparam int NL = 4;
`ifdef CSR_VECTORED_EN
    localparam bit          VEC      = 1'b1;
    localparam logic [31:0] TVEC_WR  = 32'h101;
    localparam logic [31:0] TIMER_PC = 32'h11C;
`else
    localparam bit          VEC      = 1'b0;
    localparam logic [31:0] TVEC_WR  = 32'h100;
    localparam logic [31:0] TIMER_PC = 32'h100;
`endif
    localparam logic [31:0] IE_MASK  = 32'h888 | (((32'h1 << NL) - 32'h1) << 16);
    localparam logic [31:0] MISA     = 32'h4000_0100;

    logic clk, reset;
    logic irq_ext_in, irq_sw_in, irq_timer_in;
    logic [NL-1:0] irq_local_in;
    logic illegal_instr_in, ecall_in, ebreak_in, load_misaligned_in, store_misaligned_in;
    logic [31:0] bad_addr_in, instr_in, rs1_in, pc_in;
    logic mret_in, csr_valid_in, instret_in;
    logic [2:0] csr_op_in;
    logic [11:0] csr_addr_in;
    logic [4:0] rs1_idx_in;
    logic [31:0] csr_rdata_out, trap_pc_out, mepc_out;
    logic trap_taken_out, mret_taken_out;

    csr_trap_unit #(.XLEN(32), .NUM_LOCAL_IRQ(NL), .MHARTID_VAL(32'h0), .MISA_VAL(MISA)) dut (
        .clk(clk), .reset(reset),
        .irq_ext_in(irq_ext_in), .irq_sw_in(irq_sw_in), .irq_timer_in(irq_timer_in),
        .irq_local_in(irq_local_in),
        .illegal_instr_in(illegal_instr_in), .ecall_in(ecall_in), .ebreak_in(ebreak_in),
        .load_misaligned_in(load_misaligned_in), .store_misaligned_in(store_misaligned_in),
        .bad_addr_in(bad_addr_in), .instr_in(instr_in), .mret_in(mret_in),
        .csr_valid_in(csr_valid_in), .csr_op_in(csr_op_in), .csr_addr_in(csr_addr_in),
        .rs1_in(rs1_in), .rs1_idx_in(rs1_idx_in), .pc_in(pc_in), .instret_in(instret_in),
        .csr_rdata_out(csr_rdata_out), .trap_taken_out(trap_taken_out), .trap_pc_out(trap_pc_out),
        .mret_taken_out(mret_taken_out), .mepc_out(mepc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_run  = 0;
    int n_fail = 0;

    // Architectural state of the reference model.
    bit          m_mie, m_mpie;
    bit   [1:0]  m_mpp;
    logic [31:0] m_ie, m_ip, m_tvec, m_scratch, m_epc, m_cause, m_tval, m_inh;
    logic [63:0] m_cyc, m_ins;

    // Per-cycle expectations derived from model state and current inputs.
    bit          e_int, e_exc, e_trap, e_mret, e_we, e_cill;
    int          e_cause;
    logic [31:0] e_tval, e_old, e_new, e_tpc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_mpp = 0;
        m_ie = 0; m_ip = 0; m_tvec = 0; m_scratch = 0; m_epc = 0;
        m_cause = 0; m_tval = 0; m_inh = 0; m_cyc = 0; m_ins = 0;
    endtask

    // Returns {implemented, value} for a CSR address.
    function automatic logic [32:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, 32'(m_mpp) * 2048 + 32'(m_mpie) * 128 + 32'(m_mie) * 8};
            12'h301: return {1'b1, MISA};
            12'h304: return {1'b1, m_ie};
            12'h305: return {1'b1, m_tvec};
            12'h320: return {1'b1, m_inh};
            12'h340: return {1'b1, m_scratch};
            12'h341: return {1'b1, m_epc};
            12'h342: return {1'b1, m_cause};
            12'h343: return {1'b1, m_tval};
            12'h344: return {1'b1, m_ip};
            12'hB00: return {1'b1, m_cyc[31:0]};
            12'hB80: return {1'b1, m_cyc[63:32]};
            12'hB02: return {1'b1, m_ins[31:0]};
            12'hB82: return {1'b1, m_ins[63:32]};
            12'hF11, 12'hF12, 12'hF13, 12'hF14: return {1'b1, 32'h0};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    task automatic model_eval();
        logic [31:0] pend, src;
        logic [32:0] rd;
        int order[$];
        int x_cause;
        logic [31:0] x_tval;
        bit wr_int, ro;
        pend = m_mie ? (m_ip & m_ie) : 32'h0;
        order = {11, 3, 7};
        for (int i = 0; i < NL; i++) order.push_back(16 + i);
        e_int = 0; e_cause = 0;
        foreach (order[k]) if (!e_int && pend[order[k]]) begin e_int = 1; e_cause = order[k]; end
        rd     = m_read(csr_addr_in);
        e_old  = rd[31:0];
        wr_int = (csr_op_in == 3'b001) || (csr_op_in == 3'b101) || (rs1_idx_in != 0);
        ro     = (csr_addr_in >= 12'hF11) && (csr_addr_in <= 12'hF14);
        e_cill = csr_valid_in && (!rd[32] || (ro && wr_int));
        e_exc = 1; x_cause = 0; x_tval = 0;
        if (illegal_instr_in || e_cill) begin x_cause = 2; x_tval = instr_in; end
        else if (ecall_in)              x_cause = 11;
        else if (ebreak_in)             x_cause = 3;
        else if (load_misaligned_in)    begin x_cause = 4; x_tval = bad_addr_in; end
        else if (store_misaligned_in)   begin x_cause = 6; x_tval = bad_addr_in; end
        else e_exc = 0;
        e_trap = e_int || e_exc;
        e_tval = 0;
        if (!e_int) begin e_cause = x_cause; e_tval = x_tval; end
        e_mret = mret_in && !e_trap;
        src = csr_op_in[2] ? 32'(rs1_idx_in) : rs1_in;
        case (csr_op_in[1:0])
            2'b01:   e_new = src;
            2'b10:   e_new = e_old | src;
            default: e_new = e_old & ~src;
        endcase
        e_we  = csr_valid_in && wr_int && !e_trap;
        e_tpc = m_tvec & ~32'h3;
        if (VEC && (m_tvec % 4 == 1) && e_int) e_tpc = e_tpc + 32'(4 * e_cause);
    endtask

    task automatic model_step();
        logic [31:0] ip_next;
        ip_next = 0;
        ip_next[3]  = irq_sw_in;
        ip_next[7]  = irq_timer_in;
        ip_next[11] = irq_ext_in;
        for (int i = 0; i < NL; i++) ip_next[16+i] = irq_local_in[i];
        if (e_we && csr_addr_in == 12'hB00)      m_cyc[31:0]  = e_new;
        else if (e_we && csr_addr_in == 12'hB80) m_cyc[63:32] = e_new;
        else if (!m_inh[0])                      m_cyc = m_cyc + 1;
        if (e_we && csr_addr_in == 12'hB02)      m_ins[31:0]  = e_new;
        else if (e_we && csr_addr_in == 12'hB82) m_ins[63:32] = e_new;
        else if (instret_in && !e_trap && !m_inh[2]) m_ins = m_ins + 1;
        if (e_trap) begin
            m_epc   = pc_in & ~32'h3;
            m_cause = (e_int ? 32'h8000_0000 : 32'h0) + 32'(e_cause);
            m_tval  = e_tval;
            m_mpie  = m_mie; m_mie = 0; m_mpp = 3;
        end else if (e_mret) begin
            m_mie = m_mpie; m_mpie = 1; m_mpp = 3;
        end
        if (e_we) begin
            case (csr_addr_in)
                12'h300: begin m_mie = e_new[3]; m_mpie = e_new[7]; end
                12'h304: m_ie      = e_new & IE_MASK;
                12'h305: m_tvec    = (e_new & ~32'h3) + ((VEC && e_new % 4 == 1) ? 32'h1 : 32'h0);
                12'h320: m_inh     = e_new & 32'h5;
                12'h340: m_scratch = e_new;
                12'h341: m_epc     = e_new & ~32'h3;
                12'h342: m_cause   = e_new;
                12'h343: m_tval    = e_new;
                default: ;
            endcase
        end
        m_ip = ip_next;
    endtask

    // Compare outputs mid-cycle, then advance DUT and model across one edge.
    task automatic run_cycle();
        #1;
        model_eval();
        check("trap_taken", 32'(trap_taken_out), 32'(e_trap));
        check("mret_taken", 32'(mret_taken_out), 32'(e_mret));
        check("mepc_out", mepc_out, m_epc);
        if (e_trap) check("trap_pc", trap_pc_out, e_tpc);
        if (csr_valid_in && !e_cill) check("csr_rdata", csr_rdata_out, e_old);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        csr_valid_in = 0; csr_op_in = 0; csr_addr_in = 0; rs1_in = 0; rs1_idx_in = 0;
        illegal_instr_in = 0; ecall_in = 0; ebreak_in = 0;
        load_misaligned_in = 0; store_misaligned_in = 0; mret_in = 0; instret_in = 0;
    endtask

    task automatic csr(input logic [2:0] op, input logic [11:0] a, input logic [4:0] idx, input logic [31:0] v);
        idle();
        csr_valid_in = 1; csr_op_in = op; csr_addr_in = a; rs1_idx_in = idx; rs1_in = v;
    endtask

    task automatic rd_lit(input string name, input logic [11:0] a, input logic [31:0] exp);
        csr(3'b010, a, 5'd0, 32'hFFFF_FFFF);
        #1;
        check(name, csr_rdata_out, exp);
        run_cycle();
    endtask

    logic [11:0] addr_tab [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h320, 12'h340, 12'h341,
                                   12'h342, 12'h343, 12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                   12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'hC00};
    logic [2:0]  op_tab [6] = '{3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111};

    initial begin
        reset = 0; irq_ext_in = 0; irq_sw_in = 0; irq_timer_in = 0; irq_local_in = 0;
        bad_addr_in = 0; instr_in = 0; pc_in = 0;
        idle();
        model_reset();
        @(negedge clk);
        #1;
        check("rst_trap", 32'(trap_taken_out), 32'h0);
        check("rst_mret", 32'(mret_taken_out), 32'h0);
        check("rst_mepc", mepc_out, 32'h0);
        check("rst_trap_pc", trap_pc_out, 32'h0);
        check("rst_rdata", csr_rdata_out, 32'h0);
        @(negedge clk);
        reset = 1;

        // Timer interrupt through mtvec.
        csr(3'b001, 12'h305, 5'd5, TVEC_WR); run_cycle();
        csr(3'b110, 12'h300, 5'd8, 32'h0);   run_cycle();
        csr(3'b010, 12'h304, 5'd6, 32'h80);  run_cycle();
        idle(); irq_timer_in = 1; pc_in = 32'h2000;
        #1; check("timer_not_yet", 32'(trap_taken_out), 32'h0);
        run_cycle();
        #1; check("timer_trap", 32'(trap_taken_out), 32'h1);
        check("timer_trap_pc", trap_pc_out, TIMER_PC);
        run_cycle();
        irq_timer_in = 0;
        rd_lit("timer_mcause", 12'h342, 32'h8000_0007);
        rd_lit("timer_mepc", 12'h341, 32'h2000);
        rd_lit("timer_mstatus", 12'h300, 32'h1880);
        csr(3'b001, 12'h304, 5'd5, 32'h0); run_cycle();

        // mscratch and read-only set forms.
        csr(3'b001, 12'h340, 5'd5, 32'hAA); run_cycle();
        rd_lit("scratch_rs_x0", 12'h340, 32'hAA);
        rd_lit("scratch_kept", 12'h340, 32'hAA);
        csr(3'b110, 12'h300, 5'd8, 32'h0); run_cycle();
        csr(3'b111, 12'h300, 5'd8, 32'h0);
        #1; check("csrrci_old", csr_rdata_out, 32'h1888);
        run_cycle();
        rd_lit("csrrci_new", 12'h300, 32'h1880);

        // 64-bit cycle counter carry and inhibit.
        csr(3'b001, 12'hB80, 5'd5, 32'h0);         run_cycle();
        csr(3'b001, 12'hB00, 5'd5, 32'hFFFF_FFFF); run_cycle();
        rd_lit("mcycle_ff", 12'hB00, 32'hFFFF_FFFF);
        rd_lit("mcycleh_carry", 12'hB80, 32'h1);
        rd_lit("mcycle_wrap", 12'hB00, 32'h1);
        csr(3'b001, 12'h320, 5'd5, 32'h1); run_cycle();
        rd_lit("mcycle_inh_a", 12'hB00, 32'h3);
        rd_lit("mcycle_inh_b", 12'hB00, 32'h3);
        csr(3'b001, 12'h320, 5'd5, 32'h0); run_cycle();

        // External interrupt beats ecall; pending interrupt beats mret.
        csr(3'b010, 12'h304, 5'd5, 32'h800); run_cycle();
        csr(3'b110, 12'h300, 5'd8, 32'h0);   run_cycle();
        idle(); irq_ext_in = 1; run_cycle();
        ecall_in = 1; pc_in = 32'h3000;
        #1; check("ext_ecall_trap", 32'(trap_taken_out), 32'h1);
        run_cycle();
        rd_lit("ext_mcause", 12'h342, 32'h8000_000B);
        csr(3'b110, 12'h300, 5'd8, 32'h0); run_cycle();
        idle(); mret_in = 1;
        #1; check("mret_vs_irq_trap", 32'(trap_taken_out), 32'h1);
        check("mret_vs_irq_mret", 32'(mret_taken_out), 32'h0);
        run_cycle();
        irq_ext_in = 0;
        csr(3'b001, 12'h304, 5'd5, 32'h0); run_cycle();
        idle(); mret_in = 1;
        #1; check("mret_taken", 32'(mret_taken_out), 32'h1);
        check("mret_mepc", mepc_out, 32'h3000);
        run_cycle();

        // Illegal CSR write and misaligned load.
        csr(3'b001, 12'hB02, 5'd5, 32'h0); run_cycle();
        csr(3'b001, 12'hF11, 5'd5, 32'h55); instr_in = 32'h34A1_1073; instret_in = 1;
        #1; check("ro_write_trap", 32'(trap_taken_out), 32'h1);
        run_cycle();
        rd_lit("ro_mcause", 12'h342, 32'h2);
        rd_lit("ro_mtval", 12'h343, 32'h34A1_1073);
        rd_lit("ro_minstret", 12'hB02, 32'h0);
        idle(); load_misaligned_in = 1; bad_addr_in = 32'h1003;
        #1; check("lma_trap", 32'(trap_taken_out), 32'h1);
        run_cycle();
        rd_lit("lma_mcause", 12'h342, 32'h4);
        rd_lit("lma_mtval", 12'h343, 32'h1003);

        // Asynchronous reset in the middle of a run.
        csr(3'b001, 12'hB00, 5'd5, 32'h1234); run_cycle();
        csr(3'b010, 12'hB00, 5'd0, 32'h0);
        reset = 0;
        model_reset();
        #1; check("midrst_mcycle", csr_rdata_out, 32'h0);
        check("midrst_mepc", mepc_out, 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1;
        rd_lit("rel_mcycle0", 12'hB00, 32'h0);
        rd_lit("rel_mcycle1", 12'hB00, 32'h1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            idle();
            irq_ext_in   = ($urandom_range(0, 9) == 0);
            irq_sw_in    = ($urandom_range(0, 9) == 0);
            irq_timer_in = ($urandom_range(0, 9) == 0);
            irq_local_in = NL'($urandom & $urandom & $urandom);
            illegal_instr_in    = ($urandom_range(0, 19) == 0);
            ecall_in            = ($urandom_range(0, 19) == 0);
            ebreak_in           = ($urandom_range(0, 19) == 0);
            load_misaligned_in  = ($urandom_range(0, 19) == 0);
            store_misaligned_in = ($urandom_range(0, 19) == 0);
            mret_in    = ($urandom_range(0, 11) == 0);
            instret_in = $urandom_range(0, 1) == 1;
            pc_in = $urandom; instr_in = $urandom; bad_addr_in = $urandom;
            if (!mret_in && $urandom_range(0, 1) == 1) begin
                csr_valid_in = 1;
                csr_op_in    = op_tab[$urandom_range(0, 5)];
                csr_addr_in  = addr_tab[$urandom_range(0, 19)];
                rs1_idx_in   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                rs1_in       = $urandom;
            end
            run_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
